pkt_route_reader: RTL and testbench
===================================

PKT_ROUTE_READER -- requirements
Module: pkt_route_reader

Interface
REQ-001 SHALL have parameter FIFO_ADDR_SIZE, default 10: byte-pointer width shared with the upstream capture buffer.
REQ-002 SHALL have parameter PORT_BITS, default 2: width of m_axis_tdest.
REQ-003 SHALL have parameter MIN_LEN, default 34: minimum routable packet length in bytes (Ethernet + IPv4 header).
REQ-004 SHALL have ports in this order:
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- buf_ready  in  1  high when the upstream buffer holds a complete packet.
- buf_data_len  in  FIFO_ADDR_SIZE  packet length in bytes; valid while buf_ready is high.
- buf_read_ptr  out  FIFO_ADDR_SIZE  byte address into the buffer.
- buf_data  in  32  bytes at buf_read_ptr..+3; byte k on bits [8k+7:8k].
- buf_flush  out  1  release request; the buffer clears on its rising edge.
- m_axis_tdata  out  32  output stream data.
- m_axis_tkeep  out  4  byte enables.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tdest  out  PORT_BITS  output port for the packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream accept.
- drop_count  out  16  number of dropped packets; saturates.

Function
REQ-005 SHALL treat buf_data as valid on the first rising edge after buf_read_ptr takes a new value (1-cycle read latency); buf_read_ptr SHALL be registered.
REQ-006 SHALL implement these states: IDLE, HDR, DECIDE, FWD, FLUSH, RELEASE.
REQ-007 IDLE->HDR when buf_ready=1; in IDLE buf_read_ptr=12.
REQ-008 HDR SHALL read the ethertype (bytes 12..13, big-endian) and then the IPv4 destination address (bytes 30..33, unaligned read at ptr 30), then go to DECIDE.
REQ-009 DECIDE SHALL drop the packet (go to FLUSH, increment drop_count) if buf_data_len < MIN_LEN or ethertype != 0x0800; otherwise it SHALL latch m_axis_tdest = dst_ip last octet[PORT_BITS-1:0], set buf_read_ptr=0 and go to FWD.
REQ-010 FWD SHALL emit ceil(buf_data_len/4) beats from offset 0; buf_read_ptr steps by 4 per fetched word.
REQ-011 SHALL sustain one beat per cycle while m_axis_tready=1, using a 2-entry skid buffer to absorb the read latency; no beat SHALL be lost or duplicated under any tready pattern.
REQ-012 m_axis_tdata, tkeep, tlast and tdest SHALL stay stable while tvalid=1 and tready=0.
REQ-013 tkeep SHALL be 4'b1111 on every beat except the last, which SHALL be set by buf_data_len[1:0] (0->1111, 1->0001, 2->0011, 3->0111); tlast SHALL be high only on the last beat.
REQ-014 Bytes beyond buf_data_len SHALL be driven as 0 on the last beat.
REQ-015 After the last beat handshake: FWD->FLUSH.
REQ-016 FLUSH SHALL drive buf_flush=1 for exactly one cycle, then go to RELEASE with buf_flush=0.
REQ-017 RELEASE->IDLE only after buf_ready is sampled 0; a stale buf_ready SHALL NOT start a second read of the same packet.
REQ-018 drop_count SHALL saturate at 0xFFFF.
REQ-019 A packet with buf_data_len=MIN_LEN exactly SHALL be forwarded (9 beats, last tkeep=0011).

Reset
REQ-020 On areset=1, asynchronously: state=IDLE, buf_read_ptr=12, buf_flush=0, m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, tdest=0, drop_count=0, and the skid buffer is empty.
REQ-021 Reset during FWD SHALL abandon the packet without asserting buf_flush; the upstream block is reset by its own reset.

Structure
REQ-022 State encoding, the ethertype constant 0x0800 and the header byte offsets (12, 30) SHALL live in the shared package router_pkg.
REQ-023 The skid buffer SHALL be a sub-module named axis_skid_buf; everything else SHALL be flat.

Verification
REQ-024 IPv4 packet, len 64, dst octet 0x07, tready=1 -> 16 consecutive beats, tdest=3, last tkeep=1111, one buf_flush pulse.
REQ-025 Non-IP ethertype 0x0806, len 60 -> no tvalid, drop_count 0->1, one buf_flush pulse.
REQ-026 len 33 IPv4 -> dropped; len 34 -> 9 beats, last tkeep=0011, trailing bytes 0.
REQ-027 len 61 with tready toggled randomly -> byte-exact payload, last tkeep=0001, outputs stable while stalled.
REQ-028 buf_ready held high for 3 cycles after buf_flush -> no second packet starts until buf_ready falls and rises again.
REQ-029 areset pulsed mid-FWD -> all outputs at reset values immediately, buf_flush stays 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the packet route reader: FSM states, header offsets
// and the AXI-Stream beat payload used between the reader and its skid buffer.
package router_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DECIDE,
        FWD,
        FLUSH,
        RELEASE
    } state_t;

    localparam logic [15:0]  ETHERTYPE_IPV4 = 16'h0800;
    localparam int unsigned  ETHERTYPE_OFS  = 12;
    localparam int unsigned  IP_DST_OFS     = 30;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;

    // Byte enables of the final beat from the two low bits of the packet length.
    function automatic logic [KEEP_W-1:0] last_keep(input logic [1:0] rem);
        logic [KEEP_W-1:0] k;
        case (rem)
            2'd1:    k = 4'b0001;
            2'd2:    k = 4'b0011;
            2'd3:    k = 4'b0111;
            default: k = 4'b1111;
        endcase
        return k;
    endfunction

    function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                     input logic [KEEP_W-1:0] k);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < int'(KEEP_W); i++) begin
            m[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: a registered output slot plus one overflow slot that
// catches the word already in flight from the buffer when the sink stalls.
module axis_skid_buf
    import router_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        level_c
);

    axis_beat_t in_beat;
    axis_beat_t out_q, out_d;
    axis_beat_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       pop;

    always_comb begin
        in_beat      = {in_data, in_keep, in_last};
        pop          = out_valid_q && out_ready;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (pop || !out_valid_q) begin
            // Output slot frees up: oldest word (skid first) moves forward.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = in_beat;
                skid_valid_d = in_valid;
            end else begin
                if (in_valid) begin
                    out_d = in_beat;
                end
                out_valid_d = in_valid;
            end
        end else if (in_valid) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_keep  = out_q.keep;
    assign out_last  = out_q.last;
    assign level_c   = 2'(out_valid_q) + 2'(skid_valid_q);

endmodule

// File: rtl/pkt_route_reader.sv
// Reads a captured Ethernet frame from the upstream buffer, routes IPv4 frames
// to an output port chosen by the destination address, and drops the rest.
module pkt_route_reader
    import router_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_SIZE = 10,
    parameter int unsigned PORT_BITS      = 2,
    parameter int unsigned MIN_LEN        = 34
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      buf_ready,
    input  logic [FIFO_ADDR_SIZE-1:0] buf_data_len,
    output logic [FIFO_ADDR_SIZE-1:0] buf_read_ptr,
    input  logic [31:0]               buf_data,
    output logic                      buf_flush,
    output logic [31:0]               m_axis_tdata,
    output logic [3:0]                m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [PORT_BITS-1:0]      m_axis_tdest,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [15:0]               drop_count
);

    localparam int unsigned   AW      = FIFO_ADDR_SIZE;
    localparam logic [AW-1:0] ETH_PTR = AW'(ETHERTYPE_OFS);
    localparam logic [AW-1:0] DST_PTR = AW'(IP_DST_OFS);

    state_t               state_q, state_d;
    logic                 hdr_phase_q, hdr_phase_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        len_q, len_d;
    logic [AW-1:0]        words_q, words_d;
    logic [15:0]          etype_q, etype_d;
    logic [PORT_BITS-1:0] dst_port_q, dst_port_d;
    logic [PORT_BITS-1:0] tdest_q, tdest_d;
    logic [15:0]          drop_q, drop_d;
    logic                 flush_q, flush_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;

    logic [AW-1:0]        total_c;
    logic                 pop_c;
    logic                 issue_ok_c;
    logic [1:0]           level_c;
    logic [2:0]           occ_c;
    logic [KEEP_W-1:0]    push_keep_c;
    logic [DATA_W-1:0]    push_data_c;

    // A fetch may issue only if the word it returns is guaranteed a slot.
    always_comb begin
        total_c     = AW'(({1'b0, len_q} + (AW + 1)'(3)) >> 2);
        pop_c       = m_axis_tvalid && m_axis_tready;
        occ_c       = 3'(level_c) + 3'(inflight_q);
        issue_ok_c  = occ_c < (3'd2 + 3'(pop_c));
        push_keep_c = inflight_last_q ? last_keep(len_q[1:0]) : 4'b1111;
        push_data_c = mask_bytes(buf_data, push_keep_c);
    end

    always_comb begin
        state_d         = state_q;
        hdr_phase_d     = hdr_phase_q;
        ptr_d           = ptr_q;
        len_d           = len_q;
        words_d         = words_q;
        etype_d         = etype_q;
        dst_port_d      = dst_port_q;
        tdest_d         = tdest_q;
        drop_d          = drop_q;
        flush_d         = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d = ETH_PTR;
                if (buf_ready) begin
                    state_d     = HDR;
                    hdr_phase_d = 1'b0;
                    len_d       = buf_data_len;
                end
            end
            HDR: begin
                if (!hdr_phase_q) begin
                    etype_d     = {buf_data[7:0], buf_data[15:8]};
                    ptr_d       = DST_PTR;
                    hdr_phase_d = 1'b1;
                end else begin
                    dst_port_d = buf_data[24 +: PORT_BITS];
                    state_d    = DECIDE;
                end
            end
            DECIDE: begin
                if ((len_q < AW'(MIN_LEN)) || (etype_q != ETHERTYPE_IPV4)) begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else begin
                    tdest_d         = dst_port_q;
                    ptr_d           = '0;
                    words_d         = AW'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (total_c == AW'(1));
                    state_d         = FWD;
                end
            end
            FWD: begin
                if ((words_q < total_c) && issue_ok_c) begin
                    ptr_d           = ptr_q + AW'(4);
                    words_d         = words_q + AW'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = ((words_q + AW'(1)) == total_c);
                end
                if (pop_c && m_axis_tlast) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the buffer to report empty so a stale ready is ignored.
                if (!buf_ready) begin
                    state_d = IDLE;
                    ptr_d   = ETH_PTR;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = ETH_PTR;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= IDLE;
            hdr_phase_q     <= 1'b0;
            ptr_q           <= ETH_PTR;
            len_q           <= '0;
            words_q         <= '0;
            etype_q         <= '0;
            dst_port_q      <= '0;
            tdest_q         <= '0;
            drop_q          <= '0;
            flush_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hdr_phase_q     <= hdr_phase_d;
            ptr_q           <= ptr_d;
            len_q           <= len_d;
            words_q         <= words_d;
            etype_q         <= etype_d;
            dst_port_q      <= dst_port_d;
            tdest_q         <= tdest_d;
            drop_q          <= drop_d;
            flush_q         <= flush_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    axis_skid_buf u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (inflight_q),
        .in_data   (push_data_c),
        .in_keep   (push_keep_c),
        .in_last   (inflight_last_q),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast),
        .out_ready (m_axis_tready),
        .level_c   (level_c)
    );

    assign buf_read_ptr = ptr_q;
    assign buf_flush    = flush_q;
    assign m_axis_tdest = tdest_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_pkt_route_reader.sv
// Bench for pkt_route_reader: a byte-array capture buffer, a stream monitor and
// a reference model that rebuilds each expected frame directly from its bytes.
module tb_pkt_route_reader;

    localparam int unsigned AW = 10;

    logic          aclk = 1'b0;
    logic          areset;
    logic          buf_ready;
    logic [AW-1:0] buf_data_len;
    logic [AW-1:0] buf_read_ptr;
    logic [31:0]   buf_data;
    logic          buf_flush;
    logic [31:0]   m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic [1:0]    m_axis_tdest;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [15:0]   drop_count;

    pkt_route_reader dut (
        .aclk          (aclk),
        .areset        (areset),
        .buf_ready     (buf_ready),
        .buf_data_len  (buf_data_len),
        .buf_read_ptr  (buf_read_ptr),
        .buf_data      (buf_data),
        .buf_flush     (buf_flush),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .drop_count    (drop_count)
    );

    always #5 aclk = ~aclk;

    logic [7:0] mem [0:1023];
    assign buf_data = {mem[buf_read_ptr + 10'd3], mem[buf_read_ptr + 10'd2],
                       mem[buf_read_ptr + 10'd1], mem[buf_read_ptr]};

    typedef struct packed {
        logic [1:0]  dest;
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int unsigned len;
        logic [15:0] etype;
        logic [7:0]  dst;
        bit          rnd;
        int unsigned hold;
        bit          exp_drop;
        int unsigned exp_beats;
        logic [1:0]  exp_dest;
        logic [3:0]  exp_keep;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    beat_t cap_q[$];
    int    cap_cyc[$];
    int    cyc = 0;
    int    flush_cnt = 0;
    int    flush_long = 0;
    int    valid_cycles = 0;
    bit    ready_rand = 1'b0;
    int    exp_drops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: records handshakes, flush pulses and stall stability.
    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    bit    flush_prev = 1'b0;
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall    = 1'b0;
            flush_prev    = 1'b0;
            m_axis_tready = 1'b1;
        end else begin
            cyc++;
            if (prev_stall) begin
                chk("stall_stable",
                    64'({m_axis_tvalid, m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                    64'({1'b1, prev_beat}));
            end
            m_axis_tready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (m_axis_tvalid) valid_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_q.push_back({m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                cap_cyc.push_back(cyc);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (buf_flush && !flush_prev) flush_cnt++;
            if (buf_flush && flush_prev) flush_long++;
            flush_prev = buf_flush;
        end
    end

    task automatic build_pkt(input int unsigned len, input logic [15:0] etype, input logic [7:0] dst);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[12] = etype[15:8];
        mem[13] = etype[7:0];
        mem[33] = dst;
        if (len == 0) mem[0] = mem[0];
    endtask

    // Reference: the frame as a sequence of 4-byte beats, bytes past len zeroed.
    task automatic model(input int unsigned len, input logic [15:0] etype, input logic [7:0] dst,
                         output bit drop, output beat_t exp_q[$]);
        int unsigned n;
        beat_t b;
        exp_q.delete();
        drop = (len < 34) || (etype != 16'h0800);
        n = drop ? 0 : (len + 3) / 4;
        for (int i = 0; i < int'(n); i++) begin
            b = '0;
            b.dest = dst[1:0];
            b.last = (i == int'(n) - 1);
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < int'(len)) begin
                    b.data[8*k +: 8] = mem[4 * i + k];
                    b.keep[k] = 1'b1;
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic run_pkt(input vec_t v, input bit tab, input string tag);
        beat_t exp_q[$];
        bit    drop;
        int    f0, vc0, guard, n;
        build_pkt(v.len, v.etype, v.dst);
        model(v.len, v.etype, v.dst, drop, exp_q);
        cap_q.delete();
        cap_cyc.delete();
        @(negedge aclk);
        f0           = flush_cnt;
        vc0          = valid_cycles;
        ready_rand   = v.rnd;
        buf_data_len = AW'(v.len);
        buf_ready    = 1'b1;
        guard = 0;
        while (flush_cnt == f0 && guard < 3000) begin
            @(negedge aclk);
            guard++;
        end
        chk({tag, "_flush_seen"}, 64'(flush_cnt != f0), 64'(1));
        repeat (v.hold) @(negedge aclk);
        buf_ready = 1'b0;
        repeat (12) @(negedge aclk);
        if (drop) exp_drops++;
        chk({tag, "_flush_once"}, 64'(flush_cnt - f0), 64'(1));
        chk({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
        chk({tag, "_beats"}, 64'(cap_q.size()), 64'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, 64'(cap_q[i]), 64'(exp_q[i]));
        if (drop) chk({tag, "_no_valid"}, 64'(valid_cycles - vc0), 64'(0));
        if (!drop && !v.rnd && cap_cyc.size() > 0)
            chk({tag, "_back_to_back"}, 64'(cap_cyc[cap_cyc.size()-1] - cap_cyc[0]),
                64'(exp_q.size() - 1));
        if (tab) begin
            chk({tag, "_tab_drop"}, 64'(drop), 64'(v.exp_drop));
            chk({tag, "_tab_beats"}, 64'(cap_q.size()), 64'(v.exp_beats));
            if (!v.exp_drop && cap_q.size() > 0) begin
                chk({tag, "_tab_dest"}, 64'(cap_q[cap_q.size()-1].dest), 64'(v.exp_dest));
                chk({tag, "_tab_keep"}, 64'(cap_q[cap_q.size()-1].keep), 64'(v.exp_keep));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({tag, "_tlast"},  64'(m_axis_tlast), 64'(0));
        chk({tag, "_tkeep"},  64'(m_axis_tkeep), 64'(0));
        chk({tag, "_tdata"},  64'(m_axis_tdata), 64'(0));
        chk({tag, "_tdest"},  64'(m_axis_tdest), 64'(0));
        chk({tag, "_flush"},  64'(buf_flush), 64'(0));
        chk({tag, "_ptr"},    64'(buf_read_ptr), 64'(12));
        chk({tag, "_drops"},  64'(drop_count), 64'(0));
    endtask

    initial begin
        vec_t vecs[7];
        vec_t rv;
        int   f0, guard;

        vecs[0] = '{64, 16'h0800, 8'h07, 1'b0, 0, 1'b0, 16, 2'd3, 4'b1111};
        vecs[1] = '{60, 16'h0806, 8'h05, 1'b0, 0, 1'b1, 0,  2'd0, 4'b0000};
        vecs[2] = '{33, 16'h0800, 8'h01, 1'b0, 0, 1'b1, 0,  2'd0, 4'b0000};
        vecs[3] = '{34, 16'h0800, 8'h02, 1'b0, 0, 1'b0, 9,  2'd2, 4'b0011};
        vecs[4] = '{61, 16'h0800, 8'h0D, 1'b1, 0, 1'b0, 16, 2'd1, 4'b0001};
        vecs[5] = '{40, 16'h0800, 8'h10, 1'b0, 3, 1'b0, 10, 2'd0, 4'b1111};
        vecs[6] = '{50, 16'h0800, 8'hFE, 1'b1, 9, 1'b0, 13, 2'd2, 4'b0011};

        areset       = 1'b1;
        buf_ready    = 1'b0;
        buf_data_len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (3) @(negedge aclk);
        chk_reset_outputs("reset");
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 7; i++) run_pkt(vecs[i], 1'b1, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rv       = vecs[0];
            rv.len   = $urandom_range(20, 160);
            rv.etype = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0800;
            rv.dst   = 8'($urandom);
            rv.rnd   = 1'($urandom_range(0, 1));
            rv.hold  = $urandom_range(0, 8);
            run_pkt(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of forwarding a frame.
        build_pkt(64, 16'h0800, 8'h07);
        cap_q.delete();
        @(negedge aclk);
        ready_rand   = 1'b0;
        buf_data_len = AW'(64);
        buf_ready    = 1'b1;
        f0 = flush_cnt;
        guard = 0;
        while (cap_q.size() < 4 && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        chk("midfwd_reached", 64'(cap_q.size() >= 4), 64'(1));
        #2 areset = 1'b1;
        #1 chk_reset_outputs("midfwd_reset");
        repeat (3) begin
            @(negedge aclk);
            chk("midfwd_flush_low", 64'(buf_flush), 64'(0));
        end
        buf_ready = 1'b0;
        areset    = 1'b0;
        exp_drops = 0;
        repeat (6) @(negedge aclk);
        chk("midfwd_no_flush", 64'(flush_cnt - f0), 64'(0));
        chk("midfwd_idle_valid", 64'(m_axis_tvalid), 64'(0));

        run_pkt(vecs[3], 1'b1, "post_reset");
        run_pkt(vecs[1], 1'b1, "post_reset_drop");

        chk("flush_single_cycle", 64'(flush_long), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
